nios2_qsys_dct_packer: RTL and testbench
========================================

// Module: nios2_qsys_dct_packer
// PURPOSE
//  Packs 2-bit data-trace atoms from the Nios II OCI into 30-bit DCT frames (15 slots, 4-bit count) for the trace sink.
//  Handles frame boundaries, partial-frame flush and the idle timeout, and runs the end-of-test drain/handshake.
//  Sits between the OCI trace source and the trace buffer/test-bench monitor.
// PARAMETERS
//  ATOM_W         2    bits per trace atom
//  SLOTS          15   atoms per frame; frame width = ATOM_W*SLOTS = 30
//  CNT_W          4    width of slot counters
//  FRAME_TIMEOUT  64   idle cycles before a partial frame auto-flushes; 0 disables
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high reset
//  atom_valid      in   1   trace atom offered
//  atom_data       in   2   trace atom
//  atom_ready      out  1   atom accepted when atom_valid && atom_ready
//  flush           in   1   one-cycle request: emit the partial frame
//  frame_valid     out  1   output frame held
//  frame_data      out  30  output frame; slot i = bits [2i+1:2i]; unused slots are 0
//  frame_count     out  4   valid slots in frame_data (1..15)
//  frame_ready     in   1   sink accepts the frame when frame_valid && frame_ready
//  dct_buffer      out  30  live accumulator contents
//  dct_count       out  4   live accumulator slot count (0..15)
//  test_ending     in   1   end-of-test request; latched
//  test_has_ended  out  1   sticky: all trace drained after test_ending
// BEHAVIOUR
//  Reset: every output and all state go to 0. A reset mid-operation discards the accumulator and the held frame.
//   atom_ready returns to 1 on the first cycle after reset deasserts.
//  States:
//   ACCUM  - accept atoms; go to DRAIN on flush or on timeout.
//   DRAIN  - atom_ready=0; emit the partial frame, then return to ACCUM.
//   ENDING - entered from any state when test_ending is sampled high; atom_ready=0; drain everything.
//   ENDED  - test_has_ended=1 and atom_ready=0 until reset.
//  Packing: an accepted atom is written to slot dct_count, then dct_count increments.
//  Full frame:
//   - atom_ready = (state==ACCUM) && (dct_count!=15).
//   - With dct_count==15, the frame transfers to the output register once the output slot is free
//     (!frame_valid || frame_ready). Transfer sets frame_valid=1 and clears dct_buffer/dct_count to 0.
//   - Latency: frame_valid rises one cycle after dct_count==15 is visible when the sink is not stalling.
//  Output hold: frame_data and frame_count are stable while frame_valid && !frame_ready.
//   The accepting edge either clears frame_valid or loads the next frame (back-to-back transfers allowed).
//  Flush:
//   - An atom accepted in the same cycle as flush is included in the flushed frame.
//   - In DRAIN with dct_count>0, transfer under the same free-slot rule.
//   - In DRAIN with dct_count==0, return to ACCUM without emitting a frame.
//   - A flush during DRAIN or ENDING is ignored.
//  Timeout:
//   - The idle counter increments each cycle dct_count>0 and no atom is accepted; it clears on an accept or a transfer.
//   - Reaching FRAME_TIMEOUT acts as flush.
//   - A timeout coincident with an external flush yields one flush only.
//  Ending:
//   - test_ending simultaneous with an atom accept: the atom is kept.
//   - ENDING transfers any partial frame.
//   - test_has_ended sets on the edge where dct_count==0 and (!frame_valid || frame_ready).
//   - An empty accumulator with no held frame reaches ENDED one cycle after test_ending.
// TESTING
//  1. 15 atoms alternating 2'b01/2'b10, frame_ready=1 -> one frame, frame_data=30'h19999999, frame_count=4'hF, dct_count back to 0.
//  2. 3 atoms 2'b11 then flush pulse -> frame_data=30'h3F, frame_count=3; atom_ready=0 during DRAIN.
//  3. frame_ready=0 while 30 atoms are offered -> first frame held stable, dct_count stops at 15, atom_ready=0;
//     raise frame_ready -> both frames accepted in order, no atom lost.
//  4. FRAME_TIMEOUT=8, one atom 2'b10 then idle -> frame after 8 idle cycles, frame_count=1, frame_data=30'h2.
//  5. 5 atoms 2'b01 then test_ending, frame_ready=1 -> frame_count=5, frame_data=30'h155;
//     test_has_ended=1 on the handshake edge; further atom_valid ignored.
//  6. 7 atoms then reset high one cycle -> dct_count=0, dct_buffer=0, frame_valid=0, no frame emitted.

Source files
------------

// File: rtl/nios2_qsys_dct_packer.sv
// Packs 2-bit Nios II data-trace atoms into 30-bit DCT frames with flush, idle timeout and
// end-of-test drain. Valid/ready: a beat moves on the clock edge where valid && ready are both high.
module nios2_qsys_dct_packer #(
    parameter int ATOM_W        = 2,
    parameter int SLOTS         = 15,
    parameter int CNT_W         = 4,
    parameter int FRAME_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom_data,
    output logic                      atom_ready,
    input  logic                      flush,
    output logic                      frame_valid,
    output logic [ATOM_W*SLOTS-1:0]   frame_data,
    output logic [CNT_W-1:0]          frame_count,
    input  logic                      frame_ready,
    output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    output logic                      test_has_ended
);

    localparam int FRAME_W = ATOM_W * SLOTS;
    localparam int IDLE_W  = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SLOTS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ENDING = 2'd2,
        ST_ENDED  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [FRAME_W-1:0]   fdata_q, fdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     fcount_q, fcount_d;
    logic                 fvalid_q, fvalid_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;

    logic slot_free;
    logic accept;
    logic timeout_hit;
    logic flush_req;
    logic ending_req;
    logic transfer;

    // The timeout fires on the idle cycle that would take the counter to FRAME_TIMEOUT.
    always_comb begin
        slot_free   = !fvalid_q || frame_ready;
        accept      = atom_valid && atom_ready;
        timeout_hit = (FRAME_TIMEOUT != 0) && (state_q == ST_ACCUM) && (cnt_q != '0)
                      && !accept && (idle_q == IDLE_LAST);
        flush_req   = flush || timeout_hit;
        ending_req  = (state_q == ST_ENDING) || (test_ending && (state_q != ST_ENDED));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ending_req) begin
            state_d = ((cnt_q == '0) && slot_free && !accept) ? ST_ENDED : ST_ENDING;
        end else begin
            case (state_q)
                ST_ACCUM: if (flush_req) state_d = ST_DRAIN;
                ST_DRAIN: if ((cnt_q == '0) || transfer) state_d = ST_ACCUM;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        atom_ready     = !reset && (state_q == ST_ACCUM) && (cnt_q != FULL_CNT);
        test_has_ended = (state_q == ST_ENDED);
        case (state_q)
            ST_ACCUM:            transfer = (cnt_q == FULL_CNT) && slot_free;
            ST_DRAIN, ST_ENDING: transfer = (cnt_q != '0) && slot_free;
            default:             transfer = 1'b0;
        endcase
    end

    // Accept and transfer never coincide: ACCUM transfers only when full, other states never accept.
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        fdata_d  = fdata_q;
        fcount_d = fcount_q;
        fvalid_d = fvalid_q;
        idle_d   = '0;

        if (transfer) begin
            fdata_d  = buf_q;
            fcount_d = cnt_q;
            fvalid_d = 1'b1;
            buf_d    = '0;
            cnt_d    = '0;
        end else if (frame_ready) begin
            fvalid_d = 1'b0;
        end

        if (accept) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    buf_d[i*ATOM_W +: ATOM_W] = atom_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!accept && !transfer && !flush_req && (state_q == ST_ACCUM) && (cnt_q != '0)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            fdata_q  <= '0;
            fcount_q <= '0;
            fvalid_q <= 1'b0;
            idle_q   <= '0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            fdata_q  <= fdata_d;
            fcount_q <= fcount_d;
            fvalid_q <= fvalid_d;
            idle_q   <= idle_d;
        end
    end

    assign frame_valid = fvalid_q;
    assign frame_data  = fdata_q;
    assign frame_count = fcount_q;
    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;

endmodule

// File: tb/tb_nios2_qsys_dct_packer.sv
// Bench for nios2_qsys_dct_packer: directed scenarios plus randomized traffic checked against
// an atom-queue model (every accepted atom must reappear, in order, in the emitted frames).
module tb_nios2_qsys_dct_packer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'b00;
    logic        atom_ready;
    logic        flush = 1'b0;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        frame_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending = 1'b0;
    logic        test_has_ended;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] exp_q[$];

    nios2_qsys_dct_packer #(
        .ATOM_W(2), .SLOTS(15), .CNT_W(4), .FRAME_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
        .flush(flush),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_count(frame_count),
        .frame_ready(frame_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slot i of a frame holds the i-th oldest atom; slots beyond n stay zero.
    function automatic logic [29:0] pack_atoms(input int first, input int n);
        logic [29:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (30'(exp_q[first + i]) << (2 * i));
        return v;
    endfunction

    // Scoreboard: sampled on the falling edge, so it sees the values the next rising edge acts on.
    logic        hold_prev = 1'b0;
    logic [29:0] hold_data;
    logic [3:0]  hold_cnt;
    int          inflight;
    int          mon_n;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(frame_valid), 1);
                    check("hold_data", 32'(frame_data), 32'(hold_data));
                    check("hold_count", 32'(frame_count), 32'(hold_cnt));
                end
                inflight = frame_valid ? int'(frame_count) : 0;
                check("atom_conservation", 32'(int'(dct_count) + inflight), 32'(exp_q.size()));
                if (exp_q.size() >= int'(dct_count))
                    check("dct_buffer", 32'(dct_buffer),
                          32'(pack_atoms(exp_q.size() - int'(dct_count), int'(dct_count))));
                if (frame_valid && frame_ready) begin
                    mon_n = int'(frame_count);
                    check("frame_count_range", 32'(mon_n >= 1 && mon_n <= 15), 1);
                    if (exp_q.size() >= mon_n) begin
                        check("frame_data", 32'(frame_data), 32'(pack_atoms(0, mon_n)));
                        repeat (mon_n) void'(exp_q.pop_front());
                    end else begin
                        check("frame_underflow", 32'(exp_q.size()), 32'(mon_n));
                        exp_q.delete();
                    end
                end
                if (atom_valid && atom_ready) exp_q.push_back(atom_data);
                hold_prev = frame_valid && !frame_ready;
                hold_data = frame_data;
                hold_cnt  = frame_count;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        atom_valid = 1'b0;
        flush = 1'b0;
        test_ending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_frame_data", 32'(frame_data), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_dct_buffer", 32'(dct_buffer), 0);
        check("rst_dct_count", 32'(dct_count), 0);
        check("rst_ended", 32'(test_has_ended), 0);
        check("rst_atom_ready", 32'(atom_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_atom_ready", 32'(atom_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic send_atom(input logic [1:0] d);
        int w;
        w = 0;
        atom_valid = 1'b1;
        atom_data = d;
        @(negedge clk);
        while (!atom_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!atom_ready) check("send_timeout", 32'(atom_ready), 1);
        @(posedge clk); #1;
        atom_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0]  t3[30];
    logic [29:0] f1, f2;
    int          lat;
    int          seen;
    int          w;
    int          pv, pr;

    initial begin
        do_reset();
        frame_ready = 1'b1;

        // 15 alternating atoms form one full frame one edge after the count reaches 15.
        for (int i = 0; i < 15; i++) send_atom((i % 2 == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
        check("t1_count15", 32'(dct_count), 15);
        check("t1_ready_low_full", 32'(atom_ready), 0);
        check("t1_no_frame_yet", 32'(frame_valid), 0);
        check("t1_buffer", 32'(dct_buffer), 'h19999999);
        @(negedge clk);
        check("t1_frame_valid", 32'(frame_valid), 1);
        check("t1_frame_data", 32'(frame_data), 'h19999999);
        check("t1_frame_count", 32'(frame_count), 15);
        check("t1_dct_count0", 32'(dct_count), 0);
        idle(2);

        // Three atoms then a flush pulse.
        for (int i = 0; i < 3; i++) send_atom(2'b11);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t2_drain_ready", 32'(atom_ready), 0);
        check("t2_drain_count", 32'(dct_count), 3);
        @(negedge clk);
        check("t2_frame_valid", 32'(frame_valid), 1);
        check("t2_frame_data", 32'(frame_data), 'h3F);
        check("t2_frame_count", 32'(frame_count), 3);
        idle(3);

        // Sink stalled while 30 atoms go in: one frame held, one full accumulator waiting.
        frame_ready = 1'b0;
        f1 = '0;
        f2 = '0;
        for (int i = 0; i < 30; i++) t3[i] = 2'($urandom_range(3, 0));
        for (int i = 0; i < 15; i++) f1 = f1 | (30'(t3[i]) << (2 * i));
        for (int i = 0; i < 15; i++) f2 = f2 | (30'(t3[15 + i]) << (2 * i));
        for (int i = 0; i < 30; i++) send_atom(t3[i]);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t3_held_data", 32'(frame_data), 32'(f1));
            check("t3_acc_full", 32'(dct_count), 15);
            check("t3_ready_low", 32'(atom_ready), 0);
        end
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(negedge clk);
        check("t3_first_out", 32'(frame_data), 32'(f1));
        @(negedge clk);
        check("t3_second_valid", 32'(frame_valid), 1);
        check("t3_second_out", 32'(frame_data), 32'(f2));
        @(negedge clk);
        check("t3_done_valid", 32'(frame_valid), 0);
        check("t3_done_count", 32'(dct_count), 0);
        idle(2);

        // Idle timeout: the flush fires on the 8th idle cycle and DRAIN loads the frame one edge later.
        send_atom(2'b10);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (frame_valid) lat = k;
        end
        check("t4_latency", 32'(lat), TO + 2);
        check("t4_frame_count", 32'(frame_count), 1);
        check("t4_frame_data", 32'(frame_data), 'h2);
        idle(3);

        // Randomized traffic with stalls, flushes and idle stretches.
        pv = 80;
        pr = 70;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) begin
                pv = int'($urandom_range(95, 5));
                pr = int'($urandom_range(95, 20));
            end
            atom_valid  = ($urandom_range(99, 0) < pv);
            atom_data   = 2'($urandom_range(3, 0));
            frame_ready = ($urandom_range(99, 0) < pr);
            flush       = ($urandom_range(99, 0) < 2);
            @(posedge clk); #1;
        end
        atom_valid = 1'b0;
        frame_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        w = 0;
        @(negedge clk);
        while ((dct_count != 0 || frame_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rand_drained", 32'(dct_count == 0 && !frame_valid), 1);
        check("rand_queue_empty", 32'(exp_q.size()), 0);
        idle(3);

        // End of test with five buffered atoms.
        for (int i = 0; i < 5; i++) send_atom(2'b01);
        test_ending = 1'b1;
        @(posedge clk); #1;
        test_ending = 1'b0;
        @(negedge clk);
        check("t5_ending_ready", 32'(atom_ready), 0);
        check("t5_not_ended_yet", 32'(test_has_ended), 0);
        @(negedge clk);
        check("t5_frame_valid", 32'(frame_valid), 1);
        check("t5_frame_data", 32'(frame_data), 'h155);
        check("t5_frame_count", 32'(frame_count), 5);
        check("t5_ended_before_hs", 32'(test_has_ended), 0);
        @(negedge clk);
        check("t5_ended", 32'(test_has_ended), 1);
        check("t5_frame_gone", 32'(frame_valid), 0);
        atom_valid = 1'b1;
        atom_data = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_ignored_ready", 32'(atom_ready), 0);
            check("t5_ignored_count", 32'(dct_count), 0);
        end
        check("t5_ended_sticky", 32'(test_has_ended), 1);
        @(posedge clk); #1;
        atom_valid = 1'b0;

        // Reset in the middle of a partial frame discards it.
        do_reset();
        for (int i = 0; i < 7; i++) send_atom(2'($urandom_range(3, 0)));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_dct_count", 32'(dct_count), 0);
        check("t6_dct_buffer", 32'(dct_buffer), 0);
        check("t6_frame_valid", 32'(frame_valid), 0);
        check("t6_ended", 32'(test_has_ended), 0);
        check("t6_atom_ready", 32'(atom_ready), 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (frame_valid) seen = 1;
        end
        check("t6_no_frame", 32'(seen), 0);

        // Empty packer ends one cycle after test_ending.
        @(posedge clk); #1;
        test_ending = 1'b1;
        @(posedge clk); #1;
        test_ending = 1'b0;
        @(negedge clk);
        check("empty_end", 32'(test_has_ended), 1);
        check("empty_end_ready", 32'(atom_ready), 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
